vga_draw_sprite: RTL and testbench

VGA_DRAW_SPRITE -- requirements
Module: vga_draw_sprite

---
 rtl/vga_draw_sprite.sv | 184 ++++++++++++++++++
 tb/tb_vga_draw_sprite.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_sprite.sv
// vga_draw_sprite: overlays a sprite fetched from an external pixel memory
// onto a VGA pixel stream. The sprite position and 2x scaling are sampled
// once per frame, at the rising edge of vblnk_in. The timing strobes and the
// background colour travel down a delay line so that they meet the sprite
// pixel returned by the memory, ROM_LAT cycles after the address is issued.
module vga_draw_sprite #(
  parameter int          SPR_W      = 48,
  parameter int          SPR_H      = 64,
  parameter int          ROM_LAT    = 1,
  parameter int          ADDR_W     = 12,
  parameter bit          TRANSP_EN  = 1'b1,
  parameter logic [11:0] TRANSP_KEY = 12'hF0F
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              scale2x,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [11:0]       rgb_pixel,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out
);

  // Layout of one delay-line word: {hit, hsync, vsync, hblnk, vblnk,
  // hcount, vcount, rgb}.
  localparam int DW      = 39;
  localparam int P_HIT   = 38;
  localparam int P_HSYNC = 37;
  localparam int P_VSYNC = 36;
  localparam int P_HBLNK = 35;
  localparam int P_VBLNK = 34;
  localparam int P_HC_HI = 33;
  localparam int P_HC_LO = 23;
  localparam int P_VC_HI = 22;
  localparam int P_VC_LO = 12;

  // Per-frame sprite placement, captured at the start of vertical blanking.
  logic [11:0] r_xl;
  logic [11:0] r_yl;
  logic        r_sl;
  logic        r_vblnk_prev;

  // Stage 0 geometry. Offsets are 13 bits wide so that a sprite corner to
  // the right of / below the beam shows up as a negative offset (bit 12 set)
  // instead of wrapping around to the opposite screen edge.
  logic [12:0]       w_dx;
  logic [12:0]       w_dy;
  logic [12:0]       w_w_lim;
  logic [12:0]       w_h_lim;
  logic [12:0]       w_u;
  logic [12:0]       w_v;
  logic              w_hit;
  logic [ADDR_W-1:0] w_addr;

  // Delay line aligning timing, background colour and hit with rgb_pixel.
  logic [DW-1:0] w_stage_in;
  logic [DW-1:0] r_dly [0:ROM_LAT];
  logic [DW-1:0] w_al;
  logic          w_transp;
  logic [11:0]   w_rgb_sel;

  // Output register contents.
  logic [ADDR_W-1:0] r_pixel_addr;
  logic [10:0]       r_hcount_out;
  logic [10:0]       r_vcount_out;
  logic              r_hsync_out;
  logic              r_vsync_out;
  logic              r_hblnk_out;
  logic              r_vblnk_out;
  logic [11:0]       r_rgb_out;

  // Latch position and scale on the 0->1 transition of vblnk_in only.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_xl         <= '0;
      r_yl         <= '0;
      r_sl         <= 1'b0;
      r_vblnk_prev <= 1'b0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (vblnk_in && !r_vblnk_prev) begin
        r_xl <= xpos;
        r_yl <= ypos;
        r_sl <= scale2x;
      end
    end
  end

  assign w_dx    = {2'b00, hcount_in} - {1'b0, r_xl};
  assign w_dy    = {2'b00, vcount_in} - {1'b0, r_yl};
  assign w_w_lim = 13'(SPR_W) << r_sl;
  assign w_h_lim = 13'(SPR_H) << r_sl;
  assign w_u     = w_dx >> r_sl;
  assign w_v     = w_dy >> r_sl;

  assign w_hit = !hblnk_in && !vblnk_in &&
                 !w_dx[12] && (w_dx < w_w_lim) &&
                 !w_dy[12] && (w_dy < w_h_lim);

  assign w_addr = ADDR_W'(w_v) * ADDR_W'(SPR_W) + ADDR_W'(w_u);

  // Issue the sprite memory address one cycle after the beam position.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_addr <= '0;
    end else begin
      r_pixel_addr <= w_hit ? w_addr : '0;
    end
  end

  assign w_stage_in = {w_hit, hsync_in, vsync_in, hblnk_in, vblnk_in,
                       hcount_in, vcount_in, rgb_in};

  // Shift beam data through ROM_LAT+1 stages to line up with rgb_pixel.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        r_dly[i] <= '0;
      end
    end else begin
      r_dly[0] <= w_stage_in;
      for (int i = 1; i <= ROM_LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign w_al     = r_dly[ROM_LAT];
  assign w_transp = TRANSP_EN && (rgb_pixel == TRANSP_KEY);

  // Pick blank black, the sprite pixel, or the delayed background.
  always_comb begin
    w_rgb_sel = w_al[11:0];
    if (w_al[P_HBLNK] || w_al[P_VBLNK]) begin
      w_rgb_sel = 12'h000;
    end else if (w_al[P_HIT] && !w_transp) begin
      w_rgb_sel = rgb_pixel;
    end
  end

  // Final output register; adds the last cycle of the ROM_LAT+2 latency.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount_out <= '0;
      r_vcount_out <= '0;
      r_hsync_out  <= 1'b0;
      r_vsync_out  <= 1'b0;
      r_hblnk_out  <= 1'b0;
      r_vblnk_out  <= 1'b0;
      r_rgb_out    <= '0;
    end else begin
      r_hcount_out <= w_al[P_HC_HI:P_HC_LO];
      r_vcount_out <= w_al[P_VC_HI:P_VC_LO];
      r_hsync_out  <= w_al[P_HSYNC];
      r_vsync_out  <= w_al[P_VSYNC];
      r_hblnk_out  <= w_al[P_HBLNK];
      r_vblnk_out  <= w_al[P_VBLNK];
      r_rgb_out    <= w_rgb_sel;
    end
  end

  assign pixel_addr = r_pixel_addr;
  assign hcount_out = r_hcount_out;
  assign vcount_out = r_vcount_out;
  assign hsync_out  = r_hsync_out;
  assign vsync_out  = r_vsync_out;
  assign hblnk_out  = r_hblnk_out;
  assign vblnk_out  = r_vblnk_out;
  assign rgb_out    = r_rgb_out;

endmodule

// File: tb/tb_vga_draw_sprite.sv
// tb_vga_draw_sprite: randomized beam stimulus around a latched sprite,
// checked cycle by cycle against a behavioural model of the overlay.
module tb_vga_draw_sprite;

  localparam int          SPR_W   = 48;
  localparam int          SPR_H   = 64;
  localparam int          ROM_LAT = 1;
  localparam int          ADDR_W  = 12;
  localparam logic [11:0] KEY     = 12'hF0F;
  localparam int          MAXC    = 8192;

  logic              pclk = 1'b0;
  logic              rst_n = 1'b0;
  logic [10:0]       hcount_in = '0;
  logic [10:0]       vcount_in = '0;
  logic              hsync_in = 1'b0;
  logic              vsync_in = 1'b0;
  logic              hblnk_in = 1'b0;
  logic              vblnk_in = 1'b0;
  logic [11:0]       rgb_in = '0;
  logic [11:0]       xpos = '0;
  logic [11:0]       ypos = '0;
  logic              scale2x = 1'b0;
  logic [ADDR_W-1:0] pixel_addr;
  logic [11:0]       rgb_pixel;
  logic [10:0]       hcount_out;
  logic [10:0]       vcount_out;
  logic              hsync_out;
  logic              vsync_out;
  logic              hblnk_out;
  logic              vblnk_out;
  logic [11:0]       rgb_out;

  vga_draw_sprite #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT), .ADDR_W(ADDR_W),
    .TRANSP_EN(1'b1), .TRANSP_KEY(KEY)
  ) dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .scale2x(scale2x),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  // Sprite memory with a read latency of ROM_LAT cycles.
  logic [11:0] rom [0:4095];
  logic [11:0] romPipe [0:ROM_LAT-1];

  always @(posedge pclk) begin
    romPipe[0] <= rom[pixel_addr];
    for (int i = 1; i < ROM_LAT; i++) romPipe[i] <= romPipe[i-1];
  end

  assign rgb_pixel = romPipe[ROM_LAT-1];

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;

  // Reference model state: sprite placement seen by the current frame.
  int   mxl = 0;
  int   myl = 0;
  int   msl = 0;
  logic prevVb = 1'b0;

  logic [ADDR_W-1:0] expAddr [0:MAXC-1];
  logic [25:0]       expTim  [0:MAXC-1];
  logic [11:0]       expRgb  [0:MAXC-1];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // One pixel clock: check what is due, drive new inputs, predict results.
  task automatic applyStimulus(input int h, input int v, input logic hb,
                               input logic vb, input int x, input int y,
                               input logic s);
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic [11:0] pix;
    logic [11:0] er;
    logic        hit;
    int          dx, dy, sc, ea;
    @(negedge pclk);
    if (cyc >= 1)
      checkOutput("pixel_addr", 32'(pixel_addr), 32'(expAddr[cyc-1]));
    if (cyc >= ROM_LAT + 2) begin
      checkOutput("timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out,
                                 hblnk_out, vblnk_out}),
                  32'(expTim[cyc-ROM_LAT-2]));
      checkOutput("rgb_out", 32'(rgb_out), 32'(expRgb[cyc-ROM_LAT-2]));
    end
    hs  = 1'($urandom);
    vs  = 1'($urandom);
    rgb = 12'($urandom);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
    xpos      = 12'(x);
    ypos      = 12'(y);
    scale2x   = s;
    if (!rst_n) begin
      expAddr[cyc] = '0;
      expTim[cyc]  = '0;
      expRgb[cyc]  = '0;
    end else begin
      sc  = (msl != 0) ? 2 : 1;
      dx  = h - mxl;
      dy  = v - myl;
      hit = !hb && !vb && dx >= 0 && dx < SPR_W * sc && dy >= 0 && dy < SPR_H * sc;
      ea  = hit ? (dy / sc) * SPR_W + dx / sc : 0;
      pix = rom[ea];
      if (hb || vb) er = 12'h000;
      else if (hit && pix != KEY) er = pix;
      else er = rgb;
      expAddr[cyc] = ADDR_W'(ea);
      expTim[cyc]  = {11'(h), 11'(v), hs, vs, hb, vb};
      expRgb[cyc]  = er;
      if (vb && !prevVb) begin
        mxl = x;
        myl = y;
        msl = int'(s);
      end
      prevVb = vb;
    end
    cyc++;
  endtask

  task automatic vblankPulse(input int x, input int y, input logic s);
    applyStimulus(0, 0, 1'b0, 1'b0, x, y, s);
    repeat (3) applyStimulus(0, 0, 1'b1, 1'b1, x, y, s);
  endtask

  task automatic randomBurst(input int n, input int hlo, input int hhi,
                             input int vlo, input int vhi,
                             input int x, input int y, input logic s);
    for (int k = 0; k < n; k++)
      applyStimulus(int'($urandom_range(hhi, hlo)), int'($urandom_range(vhi, vlo)),
                    ($urandom_range(9, 0) == 0), 1'b0, x, y, s);
  endtask

  // Asynchronous reset in the middle of traffic; in-flight pixels are lost.
  task automatic pulseReset(input int hold);
    rst_n = 1'b0;
    for (int k = 1; k <= ROM_LAT + 2; k++) begin
      if (cyc - k >= 0) begin
        expTim[cyc-k] = '0;
        expRgb[cyc-k] = '0;
      end
    end
    if (cyc >= 1) expAddr[cyc-1] = '0;
    mxl = 0;
    myl = 0;
    msl = 0;
    prevVb = 1'b0;
    #1;
    checkOutput("async_rst_addr", 32'(pixel_addr), 32'd0);
    checkOutput("async_rst_timing", 32'({hcount_out, vcount_out, hsync_out,
                                         vsync_out, hblnk_out, vblnk_out}), 32'd0);
    checkOutput("async_rst_rgb", 32'(rgb_out), 32'd0);
    randomBurst(hold, 90, 150, 45, 100, 100, 50, 1'b0);
    @(posedge pclk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 12'($urandom_range(4095, 0));
      if ($urandom_range(4, 0) == 0) rom[i] = KEY;
    end
    rom[1] = KEY;
    rom[2] = 12'h0F0;

    // Power-on reset with live inputs.
    randomBurst(3, 0, 200, 0, 200, 100, 50, 1'b0);
    #1;
    checkOutput("por_addr", 32'(pixel_addr), 32'd0);
    checkOutput("por_rgb", 32'(rgb_out), 32'd0);
    @(posedge pclk);
    #1 rst_n = 1'b1;

    // Unscaled sprite at (100,50): corners, right edge, transparency.
    vblankPulse(100, 50, 1'b0);
    applyStimulus(100, 50, 1'b0, 1'b0, 100, 50, 1'b0);
    applyStimulus(101, 50, 1'b0, 1'b0, 100, 50, 1'b0);
    applyStimulus(102, 50, 1'b0, 1'b0, 100, 50, 1'b0);
    applyStimulus(147, 50, 1'b0, 1'b0, 100, 50, 1'b0);
    applyStimulus(148, 50, 1'b0, 1'b0, 100, 50, 1'b0);
    applyStimulus(100, 113, 1'b0, 1'b0, 100, 50, 1'b0);
    applyStimulus(100, 114, 1'b0, 1'b0, 100, 50, 1'b0);
    applyStimulus(99, 50, 1'b0, 1'b0, 100, 50, 1'b0);

    // Position request changes mid-frame; only the next frame moves.
    randomBurst(300, 80, 360, 40, 130, 300, 50, 1'b0);
    vblankPulse(300, 50, 1'b0);
    randomBurst(200, 80, 360, 40, 130, 300, 50, 1'b0);

    // 2x magnification at (100,50).
    vblankPulse(100, 50, 1'b1);
    applyStimulus(100, 51, 1'b0, 1'b0, 100, 50, 1'b1);
    applyStimulus(101, 51, 1'b0, 1'b0, 100, 50, 1'b1);
    applyStimulus(102, 51, 1'b0, 1'b0, 100, 50, 1'b1);
    applyStimulus(195, 51, 1'b0, 1'b0, 100, 50, 1'b1);
    applyStimulus(196, 51, 1'b0, 1'b0, 100, 50, 1'b1);
    applyStimulus(100, 177, 1'b0, 1'b0, 100, 50, 1'b1);
    applyStimulus(100, 178, 1'b0, 1'b0, 100, 50, 1'b1);
    randomBurst(300, 90, 210, 40, 190, 100, 50, 1'b1);

    // Clipping at the right edge must not reappear on the left.
    vblankPulse(2020, 10, 1'b0);
    randomBurst(150, 2000, 2047, 0, 80, 2020, 10, 1'b0);
    randomBurst(100, 0, 40, 0, 80, 2020, 10, 1'b0);

    // Corner near 4095: width past 4095 must not wrap to small counts.
    vblankPulse(4090, 4050, 1'b1);
    randomBurst(100, 0, 60, 0, 60, 4090, 4050, 1'b1);

    // Scaled sprite hanging off the bottom-right corner.
    vblankPulse(1990, 2010, 1'b1);
    randomBurst(150, 1980, 2047, 2000, 2047, 1990, 2010, 1'b1);

    // Mid-frame reset: afterwards the sprite sits at (0,0), unscaled.
    vblankPulse(100, 50, 1'b0);
    randomBurst(50, 80, 170, 40, 130, 100, 50, 1'b0);
    pulseReset(3);
    randomBurst(150, 0, 60, 0, 80, 100, 50, 1'b0);

    // Random placements and scale settings.
    for (int f = 0; f < 4; f++) begin
      int x, y;
      logic s;
      x = int'($urandom_range(1900, 0));
      y = int'($urandom_range(1100, 0));
      s = 1'($urandom);
      vblankPulse(x, y, s);
      randomBurst(150, x, (x + 140 > 2047) ? 2047 : x + 140,
                  y, (y + 140 > 2047) ? 2047 : y + 140, x, y, s);
    end

    // Drain the pipeline so the last predictions are compared.
    repeat (ROM_LAT + 3) applyStimulus(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
